// File: rtl/fetch_unit.sv
// fetch_unit: registered-PC instruction fetch with a DEPTH-entry in-order prefetch queue,
// variable-latency memory handshake and redirect flush.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect pulses o_fetch_misalign and halts fetch.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req_vld,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_req_rdy,
    input  logic            i_imem_rsp_vld,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_insn_vld,
    output logic [31:0]     o_insn,
    output logic [XLEN-1:0] o_insn_pc,
    input  logic            i_insn_rdy,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fetch_misalign,
    output logic [XLEN-1:0] o_pc_debug
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pc [DEPTH];
    logic [31:0]     r_insn [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]   r_alloc_ptr, r_fill_ptr, r_rd_ptr, r_drop_cnt;
    logic [AW-1:0]   w_alloc_idx, w_fill_idx, w_rd_idx;
    logic [PW-1:0]   w_occ, w_drop_nxt;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_halted, w_req_vld, w_req_fire, w_insn_vld, w_pop, w_rsp_drop, w_rsp_fill;

    assign w_alloc_idx   = r_alloc_ptr[AW-1:0];
    assign w_fill_idx    = r_fill_ptr[AW-1:0];
    assign w_rd_idx      = r_rd_ptr[AW-1:0];
    assign w_occ         = r_alloc_ptr - r_rd_ptr;
    assign w_req_vld     = i_reset && (w_occ < PW'(DEPTH)) && !i_redirect && !w_halted;
    assign w_req_fire    = w_req_vld && i_imem_req_rdy;
    assign w_insn_vld    = r_filled[w_rd_idx];
    assign w_pop         = w_insn_vld && i_insn_rdy;
    assign w_rsp_drop    = i_imem_rsp_vld && (r_drop_cnt != '0);
    assign w_rsp_fill    = i_imem_rsp_vld && (r_drop_cnt == '0);
    assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);
    // Stale responses still owed by memory: pending drops plus unfilled allocations,
    // minus one if this cycle's response would otherwise have filled an entry
    assign w_drop_nxt    = r_drop_cnt - PW'(w_rsp_drop) + r_alloc_ptr - r_fill_ptr - PW'(w_rsp_fill);

    assign o_imem_req_vld  = w_req_vld;
    assign o_imem_req_addr = r_fetch_pc;
    assign o_insn_vld      = w_insn_vld;
    assign o_insn          = r_insn[w_rd_idx];
    assign o_insn_pc       = r_pc[w_rd_idx];
    assign o_pc_debug      = r_fetch_pc;

    // Queue bookkeeping: allocate on request, fill or drop on response, free on pop; redirect flushes last
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fetch_pc  <= RESET_VECTOR;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_drop_cnt  <= '0;
            r_filled    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_insn[i] <= NOP;
            end
        end else begin
            if (w_req_fire) begin
                r_pc[w_alloc_idx] <= r_fetch_pc;
                r_alloc_ptr       <= r_alloc_ptr + PW'(1);
                r_fetch_pc        <= r_fetch_pc + XLEN'(4);
            end
            if (w_rsp_drop)
                r_drop_cnt <= r_drop_cnt - PW'(1);
            if (w_rsp_fill) begin
                r_insn[w_fill_idx]   <= i_imem_rsp_data;
                r_filled[w_fill_idx] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PW'(1);
            end
            if (w_pop) begin
                r_filled[w_rd_idx] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + PW'(1);
            end
            if (i_redirect) begin
                r_alloc_ptr <= '0;
                r_fill_ptr  <= '0;
                r_rd_ptr    <= '0;
                r_filled    <= '0;
                r_fetch_pc  <= w_redirect_pc;
                r_drop_cnt  <= w_drop_nxt;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_halted, r_misalign;
    logic w_misalign;

    assign w_misalign       = |i_redirect_pc[1:0];
    assign w_halted         = r_halted;
    assign o_fetch_misalign = r_misalign;

    // A misaligned redirect flags for one cycle and parks fetch until an aligned redirect
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= i_redirect && w_misalign;
            if (i_redirect)
                r_halted <= w_misalign;
        end
    end
`else
    assign w_halted         = 1'b0;
    assign o_fetch_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table plus hand sequences for fetch_unit, with an in-order scoreboard
module tb_fetch_unit;
    localparam logic [31:0] RV = 32'h100;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, req_rdy, insn_rdy, redirect;
    logic [31:0] redirect_pc;
    logic        req_vld, rsp_vld, insn_vld, misalign;
    logic [31:0] req_addr, rsp_data, insn, insn_pc, pc_debug;
    int          mem_lat, lidx;
    int          errs = 0;
    int          checks = 0;
    logic [7:0]  pv = '0;
    logic [31:0] pa [8];
    logic [31:0] sb [$];
    logic [31:0] m_pc;

    typedef struct {
        logic        req_rdy;
        logic        insn_rdy;
        logic        rv;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;
    vec_t vt [21];

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(RV)) dut (
        .i_clk(clk), .i_reset(reset_n),
        .o_imem_req_vld(req_vld), .o_imem_req_addr(req_addr), .i_imem_req_rdy(req_rdy),
        .i_imem_rsp_vld(rsp_vld), .i_imem_rsp_data(rsp_data),
        .o_insn_vld(insn_vld), .o_insn(insn), .o_insn_pc(insn_pc), .i_insn_rdy(insn_rdy),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_fetch_misalign(misalign), .o_pc_debug(pc_debug)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory: mem_lat==0 answers in the accept cycle, otherwise mem_lat cycles later, in order
    always @(posedge clk) begin
        pv <= {pv[6:0], req_vld && req_rdy && mem_lat != 0};
        pa[0] <= req_addr;
        for (int k = 1; k < 8; k++) pa[k] <= pa[k-1];
    end
    assign lidx     = (mem_lat > 0) ? mem_lat - 1 : 0;
    assign rsp_vld  = (mem_lat == 0) ? (req_vld && req_rdy) : pv[lidx];
    assign rsp_data = mem_f((mem_lat == 0) ? req_addr : pa[lidx]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errs++;
        $display("FAIL %s", nm);
    endtask

    task automatic sb_step();
        logic [31:0] e;
        if (!reset_n) begin
            sb.delete();
            m_pc = RV;
        end else begin
            if (insn_vld && insn_rdy) begin
                if (sb.size() == 0) fail("sb_unexpected_pop");
                else begin
                    e = sb.pop_front();
                    chk("sb_pc", insn_pc, e);
                    chk("sb_insn", insn, mem_f(e));
                end
            end
            if (redirect) begin
                chk("req_withdrawn", {31'b0, req_vld}, 32'b0);
                sb.delete();
                m_pc = redirect_pc & ~32'h3;
            end else if (req_vld) begin
                chk("req_addr_model", req_addr, m_pc);
                if (req_rdy) begin
                    sb.push_back(m_pc);
                    m_pc += 32'h4;
                end
            end
        end
    endtask

    task automatic step_neg();
        @(negedge clk);
        sb_step();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        step_neg();
        to_pos();
    endtask

    task automatic set_lat(input int n);
        req_rdy = 1'b0;
        repeat (9) tick();
        mem_lat = n;
        req_rdy = 1'b1;
    endtask

    task automatic wait_head(input logic [31:0] pc, input int lim, input string nm);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            step_neg();
            if (insn_vld) begin
                seen = 1'b1;
                chk({nm, "_pc"}, insn_pc, pc);
                chk({nm, "_insn"}, insn, mem_f(pc));
            end
            to_pos();
        end
        if (!seen) fail({nm, "_timeout"});
    endtask

    initial begin
        reset_n = 1'b0; req_rdy = 1'b0; insn_rdy = 1'b0; redirect = 1'b0;
        redirect_pc = '0; mem_lat = 0; m_pc = RV;
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 32'h10c, 1'b1, 32'h108};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h114, 1'b1, 32'h108};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h118, 1'b1, 32'h108};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h118, 1'b1, 32'h108};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h118, 1'b1, 32'h108};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h118, 1'b1, 32'h10c};
        vt[10] = '{1'b1, 1'b1, 1'b1, 32'h11c, 1'b1, 32'h110};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h114};
        vt[12] = '{1'b1, 1'b1, 1'b1, 32'h124, 1'b1, 32'h118};
        vt[13] = '{1'b1, 1'b1, 1'b1, 32'h128, 1'b1, 32'h11c};
        vt[14] = '{1'b0, 1'b1, 1'b1, 32'h12c, 1'b1, 32'h120};
        vt[15] = '{1'b0, 1'b1, 1'b1, 32'h12c, 1'b1, 32'h124};
        vt[16] = '{1'b0, 1'b1, 1'b1, 32'h12c, 1'b1, 32'h128};
        vt[17] = '{1'b0, 1'b1, 1'b1, 32'h12c, 1'b0, 32'h0};
        vt[18] = '{1'b0, 1'b1, 1'b1, 32'h12c, 1'b0, 32'h0};
        vt[19] = '{1'b1, 1'b1, 1'b1, 32'h12c, 1'b0, 32'h0};
        vt[20] = '{1'b1, 1'b1, 1'b1, 32'h130, 1'b1, 32'h12c};

        repeat (3) @(posedge clk);
        step_neg();
        chk("rst_req_vld", {31'b0, req_vld}, 32'b0);
        chk("rst_insn_vld", {31'b0, insn_vld}, 32'b0);
        chk("rst_insn", insn, 32'h0000_0013);
        chk("rst_insn_pc", insn_pc, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'b0);
        chk("rst_pc_debug", pc_debug, RV);
        to_pos();
        reset_n = 1'b1;

        for (int r = 0; r < 21; r++) begin
            req_rdy  = vt[r].req_rdy;
            insn_rdy = vt[r].insn_rdy;
            step_neg();
            chk($sformatf("row%0d_req_vld", r), {31'b0, req_vld}, {31'b0, vt[r].rv});
            chk($sformatf("row%0d_req_addr", r), req_addr, vt[r].addr);
            chk($sformatf("row%0d_pc_debug", r), pc_debug, vt[r].addr);
            chk($sformatf("row%0d_insn_vld", r), {31'b0, insn_vld}, {31'b0, vt[r].v});
            if (vt[r].v) begin
                chk($sformatf("row%0d_insn_pc", r), insn_pc, vt[r].pc);
                chk($sformatf("row%0d_insn", r), insn, mem_f(vt[r].pc));
            end
            to_pos();
        end

        set_lat(4);
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        step_neg();
        to_pos();
        redirect = 1'b0;
        step_neg();
        chk("t3_req_vld", {31'b0, req_vld}, 32'b1);
        chk("t3_req_addr", req_addr, 32'h200);
        to_pos();
        wait_head(32'h200, 20, "t3_first");

        set_lat(1);
        repeat (2) tick();
        redirect = 1'b1; redirect_pc = 32'h400;
        step_neg();
        chk("t4_pre_rsp", {31'b0, rsp_vld}, 32'b1);
        chk("t4_pre_vld", {31'b0, insn_vld}, 32'b1);
        to_pos();
        redirect = 1'b0;
        step_neg();
        chk("t4_n1_vld", {31'b0, insn_vld}, 32'b0);
        chk("t4_n1_addr", req_addr, 32'h400);
        to_pos();
        step_neg();
        chk("t4_n2_vld", {31'b0, insn_vld}, 32'b0);
        to_pos();
        step_neg();
        chk("t4_n3_vld", {31'b0, insn_vld}, 32'b1);
        chk("t4_n3_pc", insn_pc, 32'h400);
        chk("t4_n3_insn", insn, mem_f(32'h400));
        to_pos();

        req_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step_neg();
            chk("t5_stall_vld", {31'b0, req_vld}, 32'b1);
            chk("t5_stall_addr", req_addr, 32'h40c);
            to_pos();
        end
        redirect = 1'b1; redirect_pc = 32'h500;
        step_neg();
        to_pos();
        redirect = 1'b0; req_rdy = 1'b1;
        step_neg();
        chk("t5_new_vld", {31'b0, req_vld}, 32'b1);
        chk("t5_new_addr", req_addr, 32'h500);
        to_pos();

        redirect = 1'b1; redirect_pc = 32'h202;
        step_neg();
        chk("t6_mis_before", {31'b0, misalign}, 32'b0);
        to_pos();
        redirect = 1'b0;
        step_neg();
        chk("t6_mis_pulse", {31'b0, misalign}, {31'b0, MIS});
        chk("t6_req_vld1", {31'b0, req_vld}, {31'b0, !MIS});
        chk("t6_pc_debug", pc_debug, 32'h200);
        to_pos();
        step_neg();
        chk("t6_mis_after", {31'b0, misalign}, 32'b0);
        chk("t6_req_vld2", {31'b0, req_vld}, {31'b0, !MIS});
        to_pos();
        redirect = 1'b1; redirect_pc = 32'h300;
        step_neg();
        to_pos();
        redirect = 1'b0;
        step_neg();
        chk("t6_resume_vld", {31'b0, req_vld}, 32'b1);
        chk("t6_resume_addr", req_addr, 32'h300);
        chk("t6_mis_clear", {31'b0, misalign}, 32'b0);
        to_pos();
        wait_head(32'h300, 10, "t6_first");

        reset_n = 1'b0;
        #1;
        chk("arst_insn_vld", {31'b0, insn_vld}, 32'b0);
        chk("arst_req_vld", {31'b0, req_vld}, 32'b0);
        chk("arst_pc_debug", pc_debug, RV);
        chk("arst_insn", insn, 32'h0000_0013);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
